// File: rtl/rf_arb_pkg.sv
// Shared types and default sizing for the register-file write arbiter.
// The index width is fixed at 5 bits for a 32-entry register file.
package rf_arb_pkg;

    localparam int XLEN         = 32;
    localparam int NREG         = 32;
    localparam int STARVE_LIMIT = 3;

    typedef logic [4:0]      reg_idx_t;
    typedef logic [XLEN-1:0] word_t;

    typedef struct packed {
        logic     valid;
        reg_idx_t rd;
        word_t    data;
    } wr_req_t;

    // x0 is hardwired to zero, so writes to it and busy tracking for it are suppressed.
    function automatic logic is_zero_reg(input reg_idx_t r);
        return (r == 5'd0);
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Busy scoreboard of outstanding load destinations.
// Provides three lookup ports that see a committing load as already done.
module rf_scoreboard #(
    parameter int NREG = rf_arb_pkg::NREG
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       set_en,
    input  logic [4:0] set_idx,
    input  logic       clr_en,
    input  logic [4:0] clr_idx,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    input  logic [4:0] rd,
    output logic       rs1_busy,
    output logic       rs2_busy,
    output logic       rd_busy
);
    import rf_arb_pkg::*;

    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_next;

    // The set is applied after the clear so a same-index reissue stays busy.
    always_comb begin
        busy_next = busy;
        if (clr_en) begin
            busy_next[clr_idx] = 1'b0;
        end
        if (set_en && !is_zero_reg(set_idx)) begin
            busy_next[set_idx] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    // The register file writes on negedge, before decode reads, so bypass the clear.
    always_comb begin
        rs1_busy = busy[rs1] && !(clr_en && (clr_idx == rs1));
        rs2_busy = busy[rs2] && !(clr_en && (clr_idx == rs2));
        rd_busy  = busy[rd]  && !(clr_en && (clr_idx == rd));
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates the single register-file write port between pipeline writeback
// and a one-entry load-return hold register, with a starvation guard for loads.
module rf_write_arbiter #(
    parameter int XLEN         = rf_arb_pkg::XLEN,
    parameter int NREG         = rf_arb_pkg::NREG,
    parameter int STARVE_LIMIT = rf_arb_pkg::STARVE_LIMIT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            wb_ready,
    input  logic            lsu_valid,
    input  logic [4:0]      lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    output logic            lsu_ready,
    input  logic            ld_issue,
    input  logic [4:0]      ld_rd,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    input  logic [4:0]      rd,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic            rd_busy,
    output logic            rf_we,
    output logic [4:0]      rf_wreg,
    output logic [XLEN-1:0] rf_wdata
);
    import rf_arb_pkg::*;

    localparam int               CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic             hold_valid;
    logic [4:0]       hold_rd;
    logic [XLEN-1:0]  hold_data;
    logic [CNT_W-1:0] starve_cnt;

    logic             force_hold;
    logic             hold_commit;
    logic             wb_commit;
    logic             lsu_accept;
    logic [4:0]       sel_rd;
    logic [XLEN-1:0]  sel_data;

    // Pipeline has priority until the held load has lost STARVE_LIMIT times in a row.
    always_comb begin
        force_hold  = hold_valid && (starve_cnt == CNT_MAX);
        hold_commit = hold_valid && (!wb_valid || force_hold);
        wb_ready    = !rst && !force_hold;
        wb_commit   = wb_valid && wb_ready;
        lsu_ready   = !rst && (!hold_valid || hold_commit);
        lsu_accept  = lsu_valid && lsu_ready;
        sel_rd      = hold_commit ? hold_rd   : wb_rd;
        sel_data    = hold_commit ? hold_data : wb_data;
        rf_we       = !rst && (hold_commit || wb_commit) && !is_zero_reg(sel_rd);
        rf_wreg     = sel_rd;
        rf_wdata    = sel_data;
    end

    // A refill in the commit cycle keeps the hold register occupied back to back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_valid <= 1'b0;
            hold_rd    <= '0;
            hold_data  <= '0;
        end else if (lsu_accept) begin
            hold_valid <= 1'b1;
            hold_rd    <= lsu_rd;
            hold_data  <= lsu_data;
        end else if (hold_commit) begin
            hold_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!hold_valid || hold_commit) begin
            starve_cnt <= '0;
        end else if (starve_cnt != CNT_MAX) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    rf_scoreboard #(
        .NREG(NREG)
    ) u_scoreboard (
        .clk     (clk),
        .rst     (rst),
        .set_en  (ld_issue),
        .set_idx (ld_rd),
        .clr_en  (hold_commit),
        .clr_idx (hold_rd),
        .rs1     (rs1),
        .rs2     (rs2),
        .rd      (rd),
        .rs1_busy(rs1_busy),
        .rs2_busy(rs2_busy),
        .rd_busy (rd_busy)
    );

endmodule
